cdb_arbiter: RTL

- Single-port common data bus (CDB) arbiter and output register for the functional-unit cluster.
- Collects completion requests from the branch, load-commit, ALU, multiplier and load units through a valid/ready handshake and grants one per cycle.
- Registers the winner onto the CDB/PRF write port and kills or updates in-flight results on branch recovery or branch-correct events.
- Replaces the fixed-priority combinational writeback mux and its ad-hoc stall signal.

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one completing functional unit per cycle
// (branch unit first, others round-robin) and registers it onto the CDB/PRF write port.
module cdb_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 6,
  parameter int BR_MASK_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_tag_i,
  input  logic [NUM_REQ*64-1:0]          req_value_i,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx_i,
  input  logic [NUM_REQ*BR_MASK_W-1:0]   req_br_mask_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  input  logic                           rob_br_recovery_i,
  input  logic                           rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0]           rob_br_tag_fix_i,
  output logic                           cdb_vld_o,
  output logic [PRF_IDX_W-1:0]           cdb_tag_o,
  output logic [63:0]                    cdb_value_o,
  output logic [ROB_IDX_W-1:0]           cdb_rob_idx_o,
  output logic [BR_MASK_W-1:0]           cdb_br_mask_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_vld;
  logic [PRF_IDX_W-1:0] r_tag;
  logic [63:0]          r_value;
  logic [ROB_IDX_W-1:0] r_rob_idx;
  logic [BR_MASK_W-1:0] r_mask;

  logic                 w_gnt_vld;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [PTR_W-1:0]     w_cand;
  logic [BR_MASK_W-1:0] w_fix_clr;

  // r_rr_ptr always lives in 1..NUM_REQ-1; the search walks forward from it and
  // wraps to 1, so requester 0 only ever wins through its absolute priority.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (!rst && !rob_br_recovery_i) begin
      if (req_vld_i[0]) begin
        w_gnt_vld = 1'b1;
      end else begin
        for (int k = NUM_REQ-1; k >= 1; k--) begin
          w_cand = PTR_W'(((int'(r_rr_ptr) - 1 + k) % (NUM_REQ-1)) + 1);
          if (req_vld_i[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
          end
        end
      end
    end
  end

  always_comb begin
    req_rdy_o = '0;
    req_rdy_o[w_gnt_idx] = w_gnt_vld;
  end

  assign w_fix_clr = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= PTR_W'(NUM_REQ-1);
      r_vld     <= 1'b0;
      r_tag     <= '0;
      r_value   <= '0;
      r_rob_idx <= '0;
      r_mask    <= '0;
    end else begin
      if (w_gnt_vld && w_gnt_idx != '0)
        r_rr_ptr <= w_gnt_idx;
      if (rob_br_recovery_i) begin
        r_vld     <= 1'b0;
        r_tag     <= '0;
        r_value   <= '0;
        r_rob_idx <= '0;
        r_mask    <= '0;
      end else if (w_gnt_vld) begin
        r_vld     <= 1'b1;
        r_tag     <= req_tag_i[w_gnt_idx*PRF_IDX_W +: PRF_IDX_W];
        r_value   <= req_value_i[w_gnt_idx*64 +: 64];
        r_rob_idx <= req_rob_idx_i[w_gnt_idx*ROB_IDX_W +: ROB_IDX_W];
        r_mask    <= req_br_mask_i[w_gnt_idx*BR_MASK_W +: BR_MASK_W] & ~w_fix_clr;
      end else begin
        r_vld  <= 1'b0;
        r_mask <= r_mask & ~w_fix_clr;
      end
    end
  end

  // A killed entry must not reach the PRF in the very cycle its branch recovers.
  assign cdb_vld_o     = r_vld & ~(rob_br_recovery_i & |(r_mask & rob_br_tag_fix_i));
  assign cdb_tag_o     = r_tag;
  assign cdb_value_o   = r_value;
  assign cdb_rob_idx_o = r_rob_idx;
  assign cdb_br_mask_o = r_mask;
endmodule
